// File: rtl/stack_pkg.sv
// Shared types and constants for the stack engine.
package stack_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdSp,
    StMem,
    StWrSp,
    StResp
  } state_e;

  localparam int unsigned WORD_BYTES_DEF = 4;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/stack_ctrl_if.sv
// Bundle of request, regbank SP, data-memory and response signals of the stack engine.
interface stack_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              op_valid;
  logic              op_ready;
  logic              op_pop;
  logic [DATA_W-1:0] op_data;
  logic              readSP;
  logic [DATA_W-1:0] sp_rdata;
  logic              writeSP;
  logic [DATA_W-1:0] write_dataSP;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  // Engine side.
  modport slave (
    input  op_valid, op_pop, op_data, sp_rdata, mem_rdata, mem_ack, resp_ready,
    output op_ready, readSP, writeSP, write_dataSP, mem_req, mem_we, mem_addr, mem_wdata,
           resp_valid, resp_data, resp_err
  );

  // Environment side: control unit, regbank and data memory.
  modport master (
    output op_valid, op_pop, op_data, sp_rdata, mem_rdata, mem_ack, resp_ready,
    input  op_ready, readSP, writeSP, write_dataSP, mem_req, mem_we, mem_addr, mem_wdata,
           resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack engine: runs one PUSH/POP at a time through the regbank SP port and data memory.
// Define STACK_BOUND_CHECK_EN to flag over/underflow instead of silently wrapping SP.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF
`ifdef STACK_BOUND_CHECK_EN
  ,
  parameter logic [DATA_W-1:0] STACK_BASE  = DATA_W'(32'h0000_0100),
  parameter logic [DATA_W-1:0] STACK_LIMIT = '0
`endif
) (
  input logic         clk,
  input logic         reset_n,
  stack_ctrl_if.slave bus
);

  state_e            state_q;
  logic              pop_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] new_sp_q;
  logic              op_ready_q;
  logic              read_sp_q;
  logic              write_sp_q;
  logic [DATA_W-1:0] write_data_sp_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;

  logic [DATA_W-1:0] step;
  logic [DATA_W-1:0] sp_dec;
  logic [DATA_W-1:0] sp_inc;
  logic              viol;

  assign step   = DATA_W'(WORD_BYTES);
  assign sp_dec = bus.sp_rdata - step;
  assign sp_inc = bus.sp_rdata + step;

`ifdef STACK_BOUND_CHECK_EN
  // A PUSH that borrows below zero is an underflow even if the wrapped value looks legal.
  assign viol = (pop_q == OP_POP) ? (bus.sp_rdata >= STACK_BASE)
                                  : ((bus.sp_rdata < step) || (sp_dec < STACK_LIMIT));
`else
  assign viol = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      pop_q           <= 1'b0;
      data_q          <= '0;
      new_sp_q        <= '0;
      op_ready_q      <= 1'b1;
      read_sp_q       <= 1'b0;
      write_sp_q      <= 1'b0;
      write_data_sp_q <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      resp_err_q      <= 1'b0;
    end else begin
      read_sp_q  <= 1'b0;
      write_sp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.op_valid && op_ready_q) begin
            pop_q      <= bus.op_pop;
            data_q     <= bus.op_data;
            op_ready_q <= 1'b0;
            read_sp_q  <= 1'b1;
            state_q    <= StRdSp;
          end
        end
        StRdSp: begin
          new_sp_q <= (pop_q == OP_POP) ? sp_inc : sp_dec;
          if (viol) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_data_q  <= '0;
            state_q      <= StResp;
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= (pop_q == OP_PUSH);
            mem_addr_q  <= (pop_q == OP_POP) ? bus.sp_rdata : sp_dec;
            mem_wdata_q <= (pop_q == OP_POP) ? '0 : data_q;
            state_q     <= StMem;
          end
        end
        StMem: begin
          if (bus.mem_ack) begin
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            resp_data_q     <= (pop_q == OP_POP) ? bus.mem_rdata : '0;
            write_sp_q      <= 1'b1;
            write_data_sp_q <= new_sp_q;
            state_q         <= StWrSp;
          end
        end
        StWrSp: begin
          write_data_sp_q <= '0;
          resp_valid_q    <= 1'b1;
          state_q         <= StResp;
        end
        StResp: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            op_ready_q   <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.op_ready     = op_ready_q;
  assign bus.readSP       = read_sp_q;
  assign bus.writeSP      = write_sp_q;
  assign bus.write_dataSP = write_data_sp_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_err     = resp_err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a small regbank SP model; adapts to STACK_BOUND_CHECK_EN.
module tb_stack_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] sp_reg;
  logic        sp_load;
  logic [31:0] sp_load_val;
  int          wr_cnt;
  int          mreq_cnt;
  int          total;
  int          bad;

  stack_ctrl_if #(.DATA_W(32)) bus ();

  stack_ctrl #(
    .DATA_W     (32),
    .WORD_BYTES (4)
`ifdef STACK_BOUND_CHECK_EN
    ,
    .STACK_BASE (32'h0000_0100),
    .STACK_LIMIT(32'h0000_00F8)
`endif
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.sp_rdata = sp_reg;

  // Regbank SP register plus activity counters.
  always @(posedge clk) begin
    if (bus.writeSP) sp_reg <= bus.write_dataSP;
    else if (sp_load) sp_reg <= sp_load_val;
    if (bus.writeSP) wr_cnt <= wr_cnt + 1;
    if (bus.mem_req) mreq_cnt <= mreq_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_sp(input logic [31:0] v);
    sp_load     = 1'b1;
    sp_load_val = v;
    @(negedge clk);
    sp_load = 1'b0;
  endtask

  // Called and returns at a negedge; checks every cycle of the operation at fixed offsets.
  task automatic do_op(input string tag, input logic pop, input logic [31:0] data, input int w,
                       input logic [31:0] rdata, input logic [31:0] exp_addr,
                       input logic [31:0] exp_sp, input logic exp_err, input int hold);
    int          wr0;
    int          mr0;
    logic [31:0] exp_rd;
    wr0    = wr_cnt;
    mr0    = mreq_cnt;
    exp_rd = (pop && !exp_err) ? rdata : 32'h0;
    check({tag, " op_ready idle"}, bus.op_ready, 1'b1);
    bus.op_valid = 1'b1;
    bus.op_pop   = pop;
    bus.op_data  = data;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_data  = 32'h0;
    check({tag, " readSP"}, bus.readSP, 1'b1);
    check({tag, " op_ready busy"}, bus.op_ready, 1'b0);
    @(negedge clk);
    check({tag, " readSP one cycle"}, bus.readSP, 1'b0);
    if (!exp_err) begin
      check({tag, " mem_req"}, bus.mem_req, 1'b1);
      check({tag, " mem_we"}, bus.mem_we, !pop);
      check({tag, " mem_addr"}, bus.mem_addr, exp_addr);
      check({tag, " mem_wdata"}, bus.mem_wdata, pop ? 32'h0 : data);
      for (int i = 0; i < w; i++) begin
        @(negedge clk);
        check({tag, " mem_req held"}, bus.mem_req, 1'b1);
        check({tag, " mem_addr held"}, bus.mem_addr, exp_addr);
        check({tag, " no early writeSP"}, bus.writeSP, 1'b0);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      check({tag, " writeSP"}, bus.writeSP, 1'b1);
      check({tag, " write_dataSP"}, bus.write_dataSP, exp_sp);
      check({tag, " mem_req dropped"}, bus.mem_req, 1'b0);
      @(negedge clk);
      check({tag, " writeSP one cycle"}, bus.writeSP, 1'b0);
    end else begin
      check({tag, " no mem_req"}, bus.mem_req, 1'b0);
    end
    check({tag, " resp_valid"}, bus.resp_valid, 1'b1);
    check({tag, " resp_data"}, bus.resp_data, exp_rd);
    check({tag, " resp_err"}, bus.resp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      bus.op_valid = 1'b1;
      bus.op_pop   = 1'b0;
      @(negedge clk);
      check({tag, " hold resp_valid"}, bus.resp_valid, 1'b1);
      check({tag, " hold resp_data"}, bus.resp_data, exp_rd);
      check({tag, " hold op_ready"}, bus.op_ready, 1'b0);
    end
    bus.op_valid   = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, " resp_valid cleared"}, bus.resp_valid, 1'b0);
    check({tag, " op_ready back"}, bus.op_ready, 1'b1);
    check({tag, " no stray accept"}, bus.readSP, 1'b0);
    check({tag, " sp_reg"}, sp_reg, exp_sp);
    check({tag, " writeSP count"}, 32'(wr_cnt - wr0), exp_err ? 32'd0 : 32'd1);
    if (exp_err) check({tag, " mem_req count"}, 32'(mreq_cnt - mr0), 32'd0);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    wr_cnt         = 0;
    mreq_cnt       = 0;
    sp_load        = 1'b0;
    sp_load_val    = 32'h0;
    reset_n        = 1'b0;
    bus.op_valid   = 1'b0;
    bus.op_pop     = 1'b0;
    bus.op_data    = 32'h0;
    bus.mem_rdata  = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("rst op_ready", bus.op_ready, 1'b1);
    check("rst mem_req", bus.mem_req, 1'b0);
    check("rst readSP", bus.readSP, 1'b0);
    check("rst writeSP", bus.writeSP, 1'b0);
    check("rst resp_valid", bus.resp_valid, 1'b0);
    check("rst resp_data", bus.resp_data, 32'h0);
    check("rst resp_err", bus.resp_err, 1'b0);
    set_sp(32'h100);

    do_op("push1", 1'b0, 32'hDEADBEEF, 0, 32'h0, 32'hFC, 32'hFC, 1'b0, 0);
    do_op("pop1", 1'b1, 32'h0, 3, 32'h12345678, 32'hFC, 32'h100, 1'b0, 5);

    // Reset while the memory request is pending.
    check("rstmem op_ready", bus.op_ready, 1'b1);
    bus.op_valid = 1'b1;
    bus.op_pop   = 1'b0;
    bus.op_data  = 32'hCAFE;
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("rstmem mem_req", bus.mem_req, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rstmem mem_req async", bus.mem_req, 1'b0);
    check("rstmem readSP", bus.readSP, 1'b0);
    check("rstmem writeSP", bus.writeSP, 1'b0);
    check("rstmem resp_valid", bus.resp_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    check("rstmem sp kept", sp_reg, 32'h100);
    do_op("push after rst", 1'b0, 32'hAB, 1, 32'h0, 32'hFC, 32'hFC, 1'b0, 0);

    set_sp(32'h100);
    do_op("b2b push a", 1'b0, 32'h11, 0, 32'h0, 32'hFC, 32'hFC, 1'b0, 0);
    do_op("b2b push b", 1'b0, 32'h22, 0, 32'h0, 32'hF8, 32'hF8, 1'b0, 0);

    set_sp(32'hFFFF_FFFC);
`ifdef STACK_BOUND_CHECK_EN
    do_op("pop high err", 1'b1, 32'h0, 0, 32'h55, 32'h0, 32'hFFFF_FFFC, 1'b1, 0);
    set_sp(32'h100);
    do_op("pop at base", 1'b1, 32'h0, 0, 32'h55, 32'h0, 32'h100, 1'b1, 2);
    set_sp(32'hF8);
    do_op("push at limit", 1'b0, 32'h77, 0, 32'h0, 32'h0, 32'hF8, 1'b1, 0);
    set_sp(32'h0);
    do_op("push wrap err", 1'b0, 32'h77, 0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
`else
    do_op("pop wrap", 1'b1, 32'h0, 0, 32'h55, 32'hFFFF_FFFC, 32'h0, 1'b0, 0);
    do_op("push wrap", 1'b0, 32'h77, 2, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Initiator-side stack engine for the register bank's stack-pointer port (register 31): executes PUSH/POP requests from the datapath.
- Per operation: reads SP through readSP, performs one data-memory access, writes the updated SP back through writeSP, then returns a response.
- Sits between the control unit, the regbank SP ports and the data-memory request port.

Parameters:
- DATA_W, 32, width of data, SP and memory address.
- WORD_BYTES, 4, SP step per PUSH/POP.
- STACK_BASE, 32'h0000_0100, top of stack (empty SP value); used only with STACK_BOUND_CHECK_EN.
- STACK_LIMIT, 32'h0000_0000, lowest legal stack address; used only with STACK_BOUND_CHECK_EN.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  request valid.
- op_ready  out  1  request accepted when op_valid && op_ready.
- op_pop  in  1  0 = PUSH, 1 = POP.
- op_data  in  DATA_W  PUSH value.
- readSP  out  1  to regbank: read_data1 returns SP.
- sp_rdata  in  DATA_W  regbank read_data1.
- writeSP  out  1  to regbank SP write enable.
- write_dataSP  out  DATA_W  new SP value.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write (PUSH).
- mem_addr  out  DATA_W  byte address.
- mem_wdata  out  DATA_W  PUSH data.
- mem_rdata  in  DATA_W  POP data, valid with mem_ack.
- mem_ack  in  1  completes the request.
- resp_valid  out  1  operation complete.
- resp_ready  in  1  response consumed.
- resp_data  out  DATA_W  popped value (0 for PUSH).
- resp_err  out  1  bound violation (always 0 without the feature).

Behaviour:
- FSM states: IDLE, RD_SP, MEM, WR_SP, RESP.
- Reset (async, any state): state IDLE. op_ready=1 once released. All other outputs 0, internal registers 0.
- IDLE: op_ready=1. On accept, latch op_pop and op_data, then go to RD_SP. op_ready=0 in every other state.
- RD_SP: readSP=1 for exactly one cycle. Capture sp_rdata at the posedge.
  - PUSH: addr = sp-WORD_BYTES, new_sp = sp-WORD_BYTES (pre-decrement).
  - POP: addr = sp, new_sp = sp+WORD_BYTES (post-increment).
  - Next state is MEM.
- MEM: mem_req=1, mem_we=!op_pop, mem_addr=addr, mem_wdata=op_data (0 for POP). All held stable until mem_ack.
  - On mem_ack: POP latches mem_rdata into resp_data; go to WR_SP.
  - mem_ack outside MEM is ignored.
- WR_SP: writeSP=1, write_dataSP=new_sp for exactly one cycle, then RESP.
- RESP: resp_valid=1; resp_data and resp_err held stable. On resp_ready go to IDLE.
- Latency: accept edge T, then RD_SP at T+1, MEM at T+2, WR_SP at T+2+w, resp_valid at T+3+w, where w = mem wait cycles (w=0 means ack in the first MEM cycle).
- SP arithmetic is modulo 2^DATA_W; wrap is silent without the feature.
- Reset mid-MEM: mem_req drops immediately, no writeSP is issued, SP in regbank is unchanged.
- Exactly one op is in flight; no back-to-back overlap. The next accept is at the earliest the cycle after the resp handshake.

Optional Feature:
- STACK_BOUND_CHECK_EN defined: at the RD_SP capture, a bound violation is flagged if either:
  - PUSH and sp-WORD_BYTES < STACK_LIMIT (unsigned, including wrap), or
  - POP and sp >= STACK_BASE.
- On violation: go RD_SP -> RESP directly with resp_err=1 and resp_data=0. No mem_req, no writeSP.
- Undefined: no check, resp_err tied 0, SP wraps.

Decomposition:
- Package stack_pkg holds:
  - state enum (IDLE, RD_SP, MEM, WR_SP, RESP);
  - WORD_BYTES default;
  - op encoding constants OP_PUSH=0, OP_POP=1.
- Single module; no sub-module. The SP adder and bound compare are a few lines of combinational logic.

Test Plan:
- PUSH 0xDEADBEEF, SP=0x100, ack same cycle -> mem write addr 0xFC data 0xDEADBEEF; writeSP with 0xFC at T+2; resp_valid at T+3, err=0.
- POP, SP=0xFC, mem_rdata=0x12345678, ack after 3 wait cycles -> mem read addr 0xFC; writeSP 0x100 at T+5; resp_data 0x12345678 at T+6.
- resp_ready low 5 cycles after POP -> resp_valid/resp_data stable, op_ready=0, a second op_valid is not accepted; accepted the cycle after the handshake.
- reset_n asserted during MEM -> mem_req, readSP, writeSP and resp_valid go 0 asynchronously, no SP write; after release, PUSH from SP=0x100 completes normally.
- Two back-to-back PUSHes (0x11, 0x22) from SP=0x100 -> writes at 0xFC then 0xF8; final writeSP 0xF8.
- Boundaries:
  - Without EN: POP at SP=0xFFFFFFFC -> writeSP 0x0.
  - With EN (STACK_BASE=0x100): POP at SP=0x100 -> resp_err=1, no mem_req, no writeSP.
  - With EN (STACK_LIMIT=0xF8): PUSH at SP=0xF8 -> err=1.
